// File: rtl/ula_arbitro.sv
// ula_arbitro: shares one combinational ALU between two requesters.
// Each accepted operation takes three cycles: accept, execute, respond.
// On a tie the requester that was not served last wins.
module ula_arbitro #(
  parameter int CONT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic [3:0]        op0,
  input  logic [3:0]        op1,
  input  logic [1:0]        a0,
  input  logic [1:0]        b0,
  input  logic [1:0]        a1,
  input  logic [1:0]        b1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              valido0,
  output logic              valido1,
  output logic [1:0]        resultado,
  output logic [3:0]        ula_sel,
  output logic [1:0]        ula_a,
  output logic [1:0]        ula_b,
  input  logic [1:0]        ula_saida,
  output logic              ocupado,
  output logic [CONT_W-1:0] cont0,
  output logic [CONT_W-1:0] cont1
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  localparam logic [CONT_W-1:0] CONT_MAX = '1;
  localparam logic [CONT_W-1:0] CONT_UM  = CONT_W'(1);

  estado_t           estado_q, estado_d;
  logic              ultimo_q, ultimo_d;
  logic              servido_q, servido_d;
  logic [3:0]        op_q, op_d;
  logic [1:0]        a_q, a_d;
  logic [1:0]        b_q, b_d;
  logic              gnt0_q, gnt0_d;
  logic              gnt1_q, gnt1_d;
  logic              valido0_q, valido0_d;
  logic              valido1_q, valido1_d;
  logic [1:0]        resultado_q, resultado_d;
  logic [CONT_W-1:0] cont0_q, cont0_d;
  logic [CONT_W-1:0] cont1_q, cont1_d;
  logic              vencedor;

  // Next-state logic: arbitration, operand capture, result capture and counters
  always_comb begin
    estado_d    = estado_q;
    ultimo_d    = ultimo_q;
    servido_d   = servido_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    valido0_d   = 1'b0;
    valido1_d   = 1'b0;
    resultado_d = resultado_q;
    cont0_d     = cont0_q;
    cont1_d     = cont1_q;
    // Single request wins outright; on a tie the one not served last wins.
    vencedor    = (req0 && req1) ? ~ultimo_q : req1;

    case (estado_q)
      OCIOSO: begin
        if (req0 || req1) begin
          estado_d  = EXECUTA;
          ultimo_d  = vencedor;
          servido_d = vencedor;
          op_d      = vencedor ? op1 : op0;
          a_d       = vencedor ? a1 : a0;
          b_d       = vencedor ? b1 : b0;
          gnt0_d    = ~vencedor;
          gnt1_d    = vencedor;
        end
      end
      EXECUTA: begin
        estado_d    = RESPONDE;
        resultado_d = ula_saida;
        valido0_d   = ~servido_q;
        valido1_d   = servido_q;
        if (!servido_q && cont0_q != CONT_MAX) cont0_d = cont0_q + CONT_UM;
        if (servido_q && cont1_q != CONT_MAX)  cont1_d = cont1_q + CONT_UM;
      end
      RESPONDE: begin
        estado_d = OCIOSO;
      end
      default: begin
        estado_d = OCIOSO;
      end
    endcase
  end

  // State register; reset aborts any in-flight operation
  always_ff @(posedge clk) begin
    if (rst) begin
      estado_q    <= OCIOSO;
      ultimo_q    <= 1'b1;
      servido_q   <= 1'b0;
      op_q        <= 4'd0;
      a_q         <= 2'd0;
      b_q         <= 2'd0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      valido0_q   <= 1'b0;
      valido1_q   <= 1'b0;
      resultado_q <= 2'd0;
      cont0_q     <= '0;
      cont1_q     <= '0;
    end else begin
      estado_q    <= estado_d;
      ultimo_q    <= ultimo_d;
      servido_q   <= servido_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      valido0_q   <= valido0_d;
      valido1_q   <= valido1_d;
      resultado_q <= resultado_d;
      cont0_q     <= cont0_d;
      cont1_q     <= cont1_d;
    end
  end

  assign gnt0      = gnt0_q;
  assign gnt1      = gnt1_q;
  assign valido0   = valido0_q;
  assign valido1   = valido1_q;
  assign resultado = resultado_q;
  assign ula_sel   = op_q;
  assign ula_a     = a_q;
  assign ula_b     = b_q;
  assign ocupado   = (estado_q != OCIOSO);
  assign cont0     = cont0_q;
  assign cont1     = cont1_q;

endmodule

// File: tb/tb_ula_arbitro.sv
// tb_ula_arbitro: directed stimulus against a transaction-level reference
// model. A small combinational ALU stand-in drives ula_saida.
module tb_ula_arbitro;
  localparam int CW = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req0 = 1'b0, req1 = 1'b0;
  logic [3:0]    op0 = 4'd0, op1 = 4'd0;
  logic [1:0]    a0 = 2'd0, b0 = 2'd0, a1 = 2'd0, b1 = 2'd0;
  logic          gnt0, gnt1, valido0, valido1, ocupado;
  logic [1:0]    resultado, ula_a, ula_b, ula_saida;
  logic [3:0]    ula_sel;
  logic [CW-1:0] cont0, cont1;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ula_arbitro #(.CONT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .op0(op0), .op1(op1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .valido0(valido0), .valido1(valido1),
    .resultado(resultado), .ula_sel(ula_sel), .ula_a(ula_a), .ula_b(ula_b),
    .ula_saida(ula_saida), .ocupado(ocupado), .cont0(cont0), .cont1(cont1)
  );

  // ALU stand-in: OR, AND, XOR, ADD, otherwise pass a
  function automatic logic [1:0] alu(input logic [3:0] op, input logic [1:0] a, input logic [1:0] b);
    case (op)
      4'b0110: alu = a | b;
      4'b1111: alu = a & b;
      4'b1000: alu = a ^ b;
      4'b0001: alu = a + b;
      default: alu = a;
    endcase
  endfunction

  assign ula_saida = alu(ula_sel, ula_a, ula_b);

  // Reference model: an accepted job occupies the arbiter for three cycles
  int         m_busy;
  int         m_who;
  logic       m_last;
  logic [3:0] m_op;
  logic [1:0] m_a, m_b, m_res;
  logic [1:0] m_gnt, m_val;
  int         m_cnt [2];

  function automatic int sat_inc(input int v);
    int lim;
    lim = (1 << CW) - 1;
    return (v < lim) ? v + 1 : v;
  endfunction

  // Predict the outputs after the coming clock edge from the current inputs
  task automatic model_step();
    if (rst) begin
      m_busy = 0; m_who = 0; m_last = 1'b1;
      m_op = 4'd0; m_a = 2'd0; m_b = 2'd0; m_res = 2'd0;
      m_gnt = 2'b00; m_val = 2'b00; m_cnt[0] = 0; m_cnt[1] = 0;
    end else begin
      m_gnt = 2'b00;
      m_val = 2'b00;
      if (m_busy == 2) begin
        m_res = alu(m_op, m_a, m_b);
        m_val[m_who] = 1'b1;
        m_cnt[m_who] = sat_inc(m_cnt[m_who]);
        m_busy = 1;
      end else if (m_busy == 1) begin
        m_busy = 0;
      end else if (req0 || req1) begin
        if (req0 && req1) m_who = m_last ? 0 : 1;
        else              m_who = req1 ? 1 : 0;
        m_last = (m_who == 1);
        m_op = (m_who == 1) ? op1 : op0;
        m_a  = (m_who == 1) ? a1 : a0;
        m_b  = (m_who == 1) ? b1 : b0;
        m_gnt[m_who] = 1'b1;
        m_busy = 2;
      end
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare every DUT output against the model
  task automatic check_all();
    chk("gnt0", int'(gnt0), int'(m_gnt[0]));
    chk("gnt1", int'(gnt1), int'(m_gnt[1]));
    chk("valido0", int'(valido0), int'(m_val[0]));
    chk("valido1", int'(valido1), int'(m_val[1]));
    chk("resultado", int'(resultado), int'(m_res));
    chk("ula_sel", int'(ula_sel), int'(m_op));
    chk("ula_a", int'(ula_a), int'(m_a));
    chk("ula_b", int'(ula_b), int'(m_b));
    chk("ocupado", int'(ocupado), (m_busy != 0) ? 1 : 0);
    chk("cont0", int'(cont0), m_cnt[0]);
    chk("cont1", int'(cont1), m_cnt[1]);
    chk("gnt_excl", int'(gnt0 & gnt1), 0);
    chk("val_excl", int'(valido0 & valido1), 0);
    if (m_val != 2'b00)
      $display("op done: req=%0d resultado=%b cont0=%0d cont1=%0d", m_who, resultado, cont0, cont1);
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  int order[$];

  initial begin
    do_reset();
    chk("reset_ocupado", int'(ocupado), 0);
    chk("reset_resultado", int'(resultado), 0);

    // Single request from requester 0
    req0 = 1'b1; op0 = 4'b0110; a0 = 2'b10; b0 = 2'b00;
    tick();
    req0 = 1'b0;
    chk("lit_gnt0", int'(gnt0), 1);
    tick();
    chk("lit_valido0", int'(valido0), 1);
    chk("lit_res_0110", int'(resultado), 2);
    chk("lit_cont0_1", int'(cont0), 1);
    tick(); tick();

    // Both held: alternation starting with requester 0
    do_reset();
    req0 = 1'b1; op0 = 4'b1111; a0 = 2'b01; b0 = 2'b01;
    req1 = 1'b1; op1 = 4'b1000; a1 = 2'b11; b1 = 2'b01;
    order.delete();
    for (int i = 0; i < 12; i++) begin
      tick();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
      if (valido0) chk("lit_res_req0", int'(resultado), 1);
      if (valido1) chk("lit_res_req1", int'(resultado), 2);
    end
    chk("lit_order_len", order.size(), 4);
    for (int i = 0; i < 4 && i < order.size(); i++) chk("lit_order", order[i], i % 2);

    // Only requester 1, then requester 0 joins and wins the tie
    do_reset();
    req0 = 1'b0; req1 = 1'b1; op1 = 4'b0001; a1 = 2'b01; b1 = 2'b01;
    for (int i = 0; i < 9; i++) tick();
    req0 = 1'b1; op0 = 4'b0110; a0 = 2'b01; b0 = 2'b10;
    order.delete();
    for (int i = 0; i < 3; i++) begin
      tick();
      if (gnt0) order.push_back(0);
      if (gnt1) order.push_back(1);
    end
    chk("lit_tie_len", order.size(), 1);
    if (order.size() > 0) chk("lit_tie_winner", order[0], 0);
    req0 = 1'b0; req1 = 1'b0;
    tick(); tick(); tick();

    // Operand change after grant must not affect the result
    do_reset();
    req0 = 1'b1; op0 = 4'b1000; a0 = 2'b01; b0 = 2'b01;
    tick();
    req0 = 1'b0; a0 = 2'b11;
    tick();
    chk("lit_frozen_res", int'(resultado), 0);
    tick(); tick();

    // Reset during EXECUTA aborts the operation
    do_reset();
    req0 = 1'b1; op0 = 4'b0110; a0 = 2'b10; b0 = 2'b01;
    tick();
    req0 = 1'b0; rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("lit_abort_val", int'(valido0), 0);
    chk("lit_abort_cont", int'(cont0), 0);
    chk("lit_abort_ocup", int'(ocupado), 0);
    tick();

    // Reset wins over a simultaneous request
    rst = 1'b1; req0 = 1'b1;
    tick();
    chk("lit_rst_prio", int'(gnt0), 0);
    rst = 1'b0; req0 = 1'b0;
    tick();

    // Counter saturation with a 2-bit counter
    do_reset();
    op0 = 4'b0001; a0 = 2'b01; b0 = 2'b10;
    for (int i = 0; i < 5; i++) begin
      req0 = 1'b1; tick();
      req0 = 1'b0; tick(); tick();
    end
    chk("lit_cont0_sat", int'(cont0), 3);
    chk("lit_cont1_zero", int'(cont1), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ula_arbitro.md
ULA_ARBITRO -- requirements
Module: ula_arbitro

Interface
REQ-001 Parameter CONT_W, default 8, width of each per-requester completed-operation counter.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 req0 / req1  input  1 each  operation request from requester 0 / 1.
REQ-005 op0 / op1  input  4 each  ALU operation code (switchs encoding) from requester 0 / 1.
REQ-006 a0, b0 / a1, b1  input  2 each  operands from requester 0 / 1.
REQ-007 gnt0 / gnt1  output  1 each  one-cycle pulse: request accepted and operands captured.
REQ-008 valido0 / valido1  output  1 each  one-cycle pulse: resultado holds the answer for that requester.
REQ-009 resultado  output  2  registered ALU result.
REQ-010 ula_sel  output  4  to ALU switchs; ula_a, ula_b  output  2 each  to ALU a, b.
REQ-011 ula_saida  input  2  combinational result from ALU saida.
REQ-012 ocupado  output  1  high whenever state is not OCIOSO.
REQ-013 cont0 / cont1  output  CONT_W each  completed operations per requester.

Function
REQ-014 FSM SHALL have three states: OCIOSO, EXECUTA, RESPONDE; OCIOSO->EXECUTA on accepted request, EXECUTA->RESPONDE, RESPONDE->OCIOSO unconditionally.
REQ-015 In OCIOSO, with only one req high, that requester SHALL be accepted at the next edge.
REQ-016 In OCIOSO, with both req high, the requester not served last (pointer ultimo) SHALL be accepted; ultimo SHALL update to the accepted requester on acceptance.
REQ-017 On acceptance edge: op/a/b of winner latched into internal registers, gnt of winner = 1 for exactly that EXECUTA cycle, other gnt = 0.
REQ-018 ula_sel/ula_a/ula_b SHALL always drive the latched registers; operand bits passed unmodified (bit ordering handled inside ALU).
REQ-019 At the EXECUTA->RESPONDE edge, resultado <= ula_saida; valido of the served requester = 1 for exactly the RESPONDE cycle.
REQ-020 resultado SHALL hold its value until the next EXECUTA->RESPONDE edge.
REQ-021 Latency: request sampled in OCIOSO at edge N -> gnt high cycle N..N+1, valido high cycle N+1..N+2; max throughput one op per 3 cycles.
REQ-022 req inputs SHALL be ignored in EXECUTA and RESPONDE; a req still high when returning to OCIOSO SHALL be treated as a new request.
REQ-023 Requester input changes after gnt SHALL NOT affect the in-flight operation.
REQ-024 cont0/cont1 SHALL increment at the edge where the corresponding valido rises, saturating at 2^CONT_W-1 (no wrap).
REQ-025 gnt0&gnt1 and valido0&valido1 SHALL never be high simultaneously.

Reset
REQ-026 On rst high at an edge: state=OCIOSO, gnt0=gnt1=0, valido0=valido1=0, resultado=2'b00, latched op/a/b=0, ultimo=1 (requester 0 wins first tie), cont0=cont1=0, ocupado=0.
REQ-027 rst during EXECUTA or RESPONDE SHALL abort the operation: no valido pulse, no counter increment.
REQ-028 rst SHALL take priority over any simultaneous request.

Verification (bench instantiates ula as the ALU)
REQ-029 After reset, req0=1 op0=4'b0110 a0=2'b10 one cycle -> gnt0 next cycle, valido0 cycle after, resultado=2'b10, cont0=1.
REQ-030 req0=req1=1 held, op0=4'b1111 a0=b0=2'b01, op1=4'b1000 a1=2'b11 b1=2'b01 -> order 0,1,0,1...; resultado 2'b01 for 0, 2'b10 for 1; gnt pulses every 3 cycles.
REQ-031 Only req1 high repeatedly -> served back-to-back every 3 cycles; req0 then asserted alongside -> req0 wins next tie.
REQ-032 req0 accepted, a0 changed to 2'b11 during EXECUTA -> resultado reflects original operands.
REQ-033 rst pulsed during EXECUTA -> no valido, cont unchanged at 0, ocupado=0 next cycle.
REQ-034 CONT_W=2, 5 ops from requester 0 -> cont0 stops at 2'b11.
